// File: rtl/regfile_if.sv
// Register-file port bundle: one write-back port, two read ports and the commit counter.
// The master side drives write-back and read requests; the slave side returns read data.
interface regfile_if;
  logic [31:0] wb_wr_data;
  logic [4:0]  wb_wr_address;
  logic        wb_wr_enable;
  logic        rd1_enable;
  logic [4:0]  rd1_address;
  logic [31:0] rd1_data;
  logic        rd2_enable;
  logic [4:0]  rd2_address;
  logic [31:0] rd2_data;
  logic [31:0] wb_count;

  modport master (
    output wb_wr_data, wb_wr_address, wb_wr_enable,
    output rd1_enable, rd1_address, rd2_enable, rd2_address,
    input  rd1_data, rd2_data, wb_count
  );

  modport slave (
    input  wb_wr_data, wb_wr_address, wb_wr_enable,
    input  rd1_enable, rd1_address, rd2_enable, rd2_address,
    output rd1_data, rd2_data, wb_count
  );
endinterface

// File: rtl/regfile.sv
// 32 x 32-bit register file: r0 hard-wired to zero, two combinational read ports with
// write-through bypass, and a wrapping count of committed writes.
module regfile (
  input  logic      clk,
  input  logic      rst_n,
  regfile_if.slave  bus
);

  logic [31:0] regs [32];
  logic [31:0] wb_count_q;
  logic        commit;

  assign commit = rst_n && bus.wb_wr_enable && (bus.wb_wr_address != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      wb_count_q <= 32'd0;
    end else if (commit) begin
      regs[bus.wb_wr_address] <= bus.wb_wr_data;
      wb_count_q              <= wb_count_q + 32'd1;
    end
  end

  // commit already folds in rst_n and the r0 check, so a bypass hit is just an address match
  function automatic logic [31:0] read_port(input logic en, input logic [4:0] addr);
    logic [31:0] data;
    data = 32'd0;
    if (rst_n && en && (addr != 5'd0)) begin
      if (commit && (addr == bus.wb_wr_address)) data = bus.wb_wr_data;
      else                                       data = regs[addr];
    end
    return data;
  endfunction

  always_comb begin
    bus.rd1_data = read_port(bus.rd1_enable, bus.rd1_address);
    bus.rd2_data = read_port(bus.rd2_enable, bus.rd2_address);
  end

  assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, bypass, r0, enable gating,
// counter wrap and mid-run reset, each checked against hand-computed values.
module tb_regfile;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  regfile_if bus ();

  regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("miscompare %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_wr_enable  = en;
    bus.wb_wr_address = addr;
    bus.wb_wr_data    = data;
  endtask

  task automatic rd(input logic en1, input logic [4:0] a1, input logic en2, input logic [4:0] a2);
    bus.rd1_enable  = en1;
    bus.rd1_address = a1;
    bus.rd2_enable  = en2;
    bus.rd2_address = a2;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    wr(1'b0, 5'd0, 32'd0);
    rd(1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    // reset asserted with a live write presented: no bypass, no commit
    rst_n = 1'b0;
    wr(1'b1, 5'd3, 32'h1111_1111);
    rd(1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    check("rst_rd1_bypass_blocked", bus.rd1_data, 32'h0);
    check("rst_rd2_bypass_blocked", bus.rd2_data, 32'h0);
    check("rst_count", bus.wb_count, 32'h0);
    tick();
    check("rst_write_ignored_count", bus.wb_count, 32'h0);

    wr(1'b0, 5'd0, 32'd0);
    #1;
    rst_n = 1'b1;
    rd(1'b1, 5'd5, 1'b1, 5'd31);
    #1;
    check("post_rst_rd1_r5", bus.rd1_data, 32'h0);
    check("post_rst_rd2_r31", bus.rd2_data, 32'h0);
    check("post_rst_count", bus.wb_count, 32'h0);
    rd(1'b1, 5'd3, 1'b0, 5'd0);
    #1;
    check("post_rst_r3_not_written", bus.rd1_data, 32'h0);

    // write then read
    wr(1'b1, 5'd7, 32'hDEAD_BEEF);
    rd(1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    wr(1'b0, 5'd0, 32'd0);
    rd(1'b1, 5'd7, 1'b1, 5'd7);
    #1;
    check("wr_rd1_r7", bus.rd1_data, 32'hDEAD_BEEF);
    check("wr_rd2_r7", bus.rd2_data, 32'hDEAD_BEEF);
    check("wr_count", bus.wb_count, 32'd1);
    rd(1'b0, 5'd7, 1'b1, 5'd7);
    #1;
    check("rd1_disabled", bus.rd1_data, 32'h0);
    check("rd2_still_enabled", bus.rd2_data, 32'hDEAD_BEEF);

    // dual-port bypass
    wr(1'b1, 5'd3, 32'h1234_5678);
    rd(1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    check("bypass_rd1", bus.rd1_data, 32'h1234_5678);
    check("bypass_rd2", bus.rd2_data, 32'h1234_5678);
    check("bypass_count_before_edge", bus.wb_count, 32'd1);
    tick();
    wr(1'b0, 5'd3, 32'h0);
    #1;
    check("bypass_r3_held_rd1", bus.rd1_data, 32'h1234_5678);
    check("bypass_r3_held_rd2", bus.rd2_data, 32'h1234_5678);
    check("bypass_count", bus.wb_count, 32'd2);

    // disabled write is neither bypassed nor committed
    wr(1'b0, 5'd7, 32'h0BAD_0BAD);
    rd(1'b1, 5'd7, 1'b0, 5'd0);
    #1;
    check("wr_dis_no_bypass", bus.rd1_data, 32'hDEAD_BEEF);
    tick();
    check("wr_dis_r7_kept", bus.rd1_data, 32'hDEAD_BEEF);
    check("wr_dis_count", bus.wb_count, 32'd2);

    // writes to r0 are discarded
    wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    rd(1'b1, 5'd0, 1'b1, 5'd3);
    #1;
    check("r0_same_cycle", bus.rd1_data, 32'h0);
    check("r0_other_port", bus.rd2_data, 32'h1234_5678);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("r0_next_cycle", bus.rd1_data, 32'h0);
    check("r0_count", bus.wb_count, 32'd2);

    // bypass on one port only
    wr(1'b1, 5'd9, 32'hCAFE_F00D);
    rd(1'b1, 5'd9, 1'b1, 5'd7);
    #1;
    check("bypass1_rd1", bus.rd1_data, 32'hCAFE_F00D);
    check("bypass1_rd2_reg", bus.rd2_data, 32'hDEAD_BEEF);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("bypass1_count", bus.wb_count, 32'd3);

    // counter wrap
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    check("wrap_preload", bus.wb_count, 32'hFFFF_FFFF);
    release dut.wb_count_q;
    wr(1'b1, 5'd12, 32'h0000_0001);
    rd(1'b1, 5'd12, 1'b0, 5'd0);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("wrap_count", bus.wb_count, 32'h0);
    check("wrap_r12", bus.rd1_data, 32'h0000_0001);

    // mid-run reset
    wr(1'b1, 5'd10, 32'hA5A5_A5A5);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    rd(1'b1, 5'd10, 1'b1, 5'd3);
    #1;
    check("mid_r10_written", bus.rd1_data, 32'hA5A5_A5A5);
    check("mid_count", bus.wb_count, 32'd1);
    wr(1'b1, 5'd10, 32'h5A5A_5A5A);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd1", bus.rd1_data, 32'h0);
    check("mid_rst_rd2", bus.rd2_data, 32'h0);
    check("mid_rst_count", bus.wb_count, 32'h0);
    wr(1'b0, 5'd0, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_post_r10", bus.rd1_data, 32'h0);
    check("mid_post_r3", bus.rd2_data, 32'h0);
    rd(1'b1, 5'd7, 1'b1, 5'd9);
    #1;
    check("mid_post_r7", bus.rd1_data, 32'h0);
    check("mid_post_r9", bus.rd2_data, 32'h0);

    // first write after release commits on the next edge
    wr(1'b1, 5'd5, 32'h0000_0077);
    rd(1'b1, 5'd5, 1'b0, 5'd0);
    tick();
    wr(1'b0, 5'd0, 32'h0);
    #1;
    check("first_wr_r5", bus.rd1_data, 32'h0000_0077);
    check("first_wr_count", bus.wb_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
